// File: rtl/fault_detector.sv
// Runtime fault detector: flags illegal opcodes, contradictory decoder controls and a stalled PC,
// holds the first fault until recovery logic resumes the CPU, and escalates repeated minor faults.
module fault_detector #(
  parameter int STUCK_LIMIT    = 16,
  parameter int ESCALATE_LIMIT = 3,
  parameter int CLEAN_WINDOW   = 64,
  parameter int BLANK_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        pc_write,
  input  logic [31:0] pc_current,
  input  logic        resume_cpu,
  output logic        illegal_opcode,
  output logic        invalid_control,
  output logic        stuck_at_fault,
  output logic [31:0] pc_saved,
  output logic        fault_active,
  output logic [7:0]  fault_count
);

  typedef enum logic [1:0] {MONITOR = 2'd0, HOLD = 2'd1, BLANK = 2'd2} state_e;

  localparam logic [7:0] STUCK_MAX  = 8'(STUCK_LIMIT);
  localparam logic [3:0] ESC_LEVEL  = 4'(ESCALATE_LIMIT);
  localparam logic [7:0] CLEAN_LAST = 8'(CLEAN_WINDOW - 1);
  localparam logic [2:0] BLANK_LAST = 3'(BLANK_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  flags_q, flags_d;          // {stuck, invalid, illegal}
  logic [31:0] pc_saved_q, pc_saved_d;
  logic [7:0]  fault_count_q, fault_count_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  clean_cnt_q, clean_cnt_d;
  logic [2:0]  blank_cnt_q, blank_cnt_d;
  logic [31:0] prev_pc_q, prev_pc_d;

  logic illegal_c, invalid_c, stuck_c, any_c, latch, escalate, resume_hold;
  logic unused_instr_hi;

  // Every accepted opcode ends in 2'b11, so this also rejects compressed encodings.
  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
      7'b0010111, 7'b1110011, 7'b0001111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign unused_instr_hi = ^instr[31:7];
  assign illegal_c   = instr_valid && !opcode_legal(instr[6:0]);
  assign invalid_c   = (mem_read & mem_write) | (mem_write & reg_write);
  assign stuck_c     = (stall_cnt_q == STUCK_MAX);
  assign any_c       = illegal_c | invalid_c | stuck_c;
  assign latch       = (state_q == MONITOR) && any_c;
  assign escalate    = !stuck_c && (streak_q >= ESC_LEVEL);
  assign resume_hold = (state_q == HOLD) && resume_cpu;

  always_ff @(posedge clk) begin
    if (reset) state_q <= MONITOR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MONITOR: if (any_c) state_d = HOLD;
      HOLD:    if (resume_cpu) state_d = BLANK;
      BLANK:   if (blank_cnt_q == BLANK_LAST) state_d = MONITOR;
      default: state_d = MONITOR;
    endcase
  end

  always_comb begin
    flags_d       = flags_q;
    pc_saved_d    = pc_saved_q;
    fault_count_d = fault_count_q;
    streak_d      = streak_q;
    clean_cnt_d   = clean_cnt_q;
    blank_cnt_d   = 3'd0;
    prev_pc_d     = pc_current;

    if (latch) begin
      pc_saved_d  = pc_current;
      clean_cnt_d = 8'd0;
      if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
      if (stuck_c || escalate) begin
        flags_d  = 3'b100;
        streak_d = 4'd0;
      end else begin
        flags_d = invalid_c ? 3'b010 : 3'b001;
        if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
      end
    end else if (state_q == MONITOR) begin
      if (clean_cnt_q == CLEAN_LAST) begin
        clean_cnt_d = 8'd0;
        streak_d    = 4'd0;
      end else begin
        clean_cnt_d = clean_cnt_q + 8'd1;
      end
    end

    if (resume_hold) flags_d = 3'b000;
    if (state_q == BLANK && blank_cnt_q != BLANK_LAST) blank_cnt_d = blank_cnt_q + 3'd1;

    // Stall counter keeps running in HOLD but is forced to zero from resume through blanking.
    if (resume_hold || state_q == BLANK)
      stall_cnt_d = 8'd0;
    else if (pc_write && pc_current == prev_pc_q)
      stall_cnt_d = (stall_cnt_q == STUCK_MAX) ? stall_cnt_q : stall_cnt_q + 8'd1;
    else
      stall_cnt_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= 3'b000;
      pc_saved_q    <= 32'd0;
      fault_count_q <= 8'd0;
      stall_cnt_q   <= 8'd0;
      streak_q      <= 4'd0;
      clean_cnt_q   <= 8'd0;
      blank_cnt_q   <= 3'd0;
      prev_pc_q     <= 32'd0;
    end else begin
      flags_q       <= flags_d;
      pc_saved_q    <= pc_saved_d;
      fault_count_q <= fault_count_d;
      stall_cnt_q   <= stall_cnt_d;
      streak_q      <= streak_d;
      clean_cnt_q   <= clean_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      prev_pc_q     <= prev_pc_d;
    end
  end

  always_comb begin
    fault_active    = (state_q == HOLD);
    stuck_at_fault  = flags_q[2];
    invalid_control = flags_q[1];
    illegal_opcode  = flags_q[0];
    pc_saved        = pc_saved_q;
    fault_count     = fault_count_q;
  end

endmodule

// File: tb/tb_fault_detector.sv
// Testbench for fault_detector: directed vector table, hand-written multi-cycle sequences,
// and a randomized run compared against a behavioural model.
module tb_fault_detector;

  localparam int STUCK_LIMIT    = 16;
  localparam int ESCALATE_LIMIT = 3;
  localparam int CLEAN_WINDOW   = 64;
  localparam int BLANK_CYCLES   = 2;

  logic        clk = 1'b0;
  logic        reset, instr_valid, reg_write, mem_write, mem_read, pc_write, resume_cpu;
  logic [31:0] instr, pc_current;
  logic        illegal_opcode, invalid_control, stuck_at_fault, fault_active;
  logic [31:0] pc_saved;
  logic [7:0]  fault_count;

  int checks = 0;
  int errors = 0;

  fault_detector #(
    .STUCK_LIMIT(STUCK_LIMIT), .ESCALATE_LIMIT(ESCALATE_LIMIT),
    .CLEAN_WINDOW(CLEAN_WINDOW), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
    .pc_write(pc_write), .pc_current(pc_current), .resume_cpu(resume_cpu),
    .illegal_opcode(illegal_opcode), .invalid_control(invalid_control),
    .stuck_at_fault(stuck_at_fault), .pc_saved(pc_saved),
    .fault_active(fault_active), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111, 7'b1110011, 7'b0001111};

  typedef struct {
    logic        rst, vld, mr, mw, rw, res;
    logic [31:0] ins, pc;
    logic [2:0]  ef;   // {stuck, invalid, illegal}
    logic        ea;
    logic [31:0] ep;
    logic [7:0]  ec;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 0; instr_valid = 0; instr = 32'h0000_0013;
    mem_read = 0; mem_write = 0; reg_write = 0; pc_write = 0; resume_cpu = 0;
  endtask

  task automatic check_all(string name, logic [2:0] ef, logic ea, logic [31:0] ep, logic [7:0] ec);
    logic [2:0] af;
    af = {stuck_at_fault, invalid_control, illegal_opcode};
    checks++;
    if (af !== ef || fault_active !== ea || pc_saved !== ep || fault_count !== ec) begin
      errors++;
      $display("FAIL %s: got flags=%b active=%b pc_saved=%h count=%0d, want flags=%b active=%b pc_saved=%h count=%0d",
               name, af, fault_active, pc_saved, fault_count, ef, ea, ep, ec);
    end
  endtask

  task automatic check_flags(string name, logic [2:0] ef, logic ea);
    logic [2:0] af;
    af = {stuck_at_fault, invalid_control, illegal_opcode};
    checks++;
    if (af !== ef || fault_active !== ea) begin
      errors++;
      $display("FAIL %s: got flags=%b active=%b, want flags=%b active=%b", name, af, fault_active, ef, ea);
    end
  endtask

  task automatic check_count(string name, logic [7:0] ec);
    checks++;
    if (fault_count !== ec) begin
      errors++;
      $display("FAIL %s: got count=%0d, want count=%0d", name, fault_count, ec);
    end
  endtask

  task automatic do_reset();
    set_idle(); reset = 1; pc_current = 32'h0; tick(); reset = 0;
  endtask

  task automatic illegal_fault(logic [31:0] pc);
    set_idle(); instr_valid = 1; instr = 32'h0000_007F; pc_current = pc; tick();
  endtask

  task automatic resume_and_blank();
    set_idle(); resume_cpu = 1; tick();
    set_idle(); tick(); tick();
  endtask

  // Three illegal faults back to back, n clean idle cycles, then a fourth illegal fault.
  task automatic three_then(int n, logic [2:0] ef, string name);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      illegal_fault(32'h1000 + 32'(i * 16));
      check_flags({name, "_minor"}, 3'b001, 1'b1);
      resume_and_blank();
    end
    set_idle();
    for (int i = 0; i < n; i++) tick();
    illegal_fault(32'h2000);
    check_flags(name, ef, 1'b1);
  endtask

  // Behavioural reference model
  int          m_mode;       // 0 monitor, 1 hold, 2 blank
  int          m_blank_left, m_run, m_streak, m_clean, m_count;
  logic [31:0] m_prev, m_pc_saved;
  logic [2:0]  m_flags;

  function automatic bit is_legal(input logic [31:0] w);
    if (w[1:0] != 2'b11) return 0;
    foreach (legal_ops[i]) if (w[6:0] == legal_ops[i]) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    bit ill, inv, stk, blanking;
    int new_run;
    if (reset) begin
      m_mode = 0; m_blank_left = 0; m_run = 0; m_streak = 0; m_clean = 0; m_count = 0;
      m_prev = 0; m_pc_saved = 0; m_flags = 0;
      return;
    end
    ill = instr_valid && !is_legal(instr);
    inv = (mem_read && mem_write) || (mem_write && reg_write);
    stk = (m_run >= STUCK_LIMIT);
    blanking = (m_mode == 1 && resume_cpu) || m_mode == 2;
    if (blanking) new_run = 0;
    else if (pc_write && pc_current == m_prev) new_run = (m_run < STUCK_LIMIT) ? m_run + 1 : m_run;
    else new_run = 0;
    case (m_mode)
      0: begin
        if (ill || inv || stk) begin
          if (m_count < 255) m_count++;
          m_pc_saved = pc_current;
          m_clean = 0;
          if (stk || m_streak >= ESCALATE_LIMIT) begin
            m_flags = 3'b100; m_streak = 0;
          end else begin
            m_flags = inv ? 3'b010 : 3'b001;
            if (m_streak < 15) m_streak++;
          end
          m_mode = 1;
        end else begin
          m_clean++;
          if (m_clean == CLEAN_WINDOW) begin m_clean = 0; m_streak = 0; end
        end
      end
      1: if (resume_cpu) begin m_flags = 0; m_mode = 2; m_blank_left = BLANK_CYCLES; end
      default: begin
        m_blank_left--;
        if (m_blank_left == 0) m_mode = 0;
      end
    endcase
    m_run = new_run;
    m_prev = pc_current;
  endtask

  vec_t tbl[$];

  initial begin
    int          stall_left, sel;
    logic [31:0] r, pc_val;

    tbl.push_back('{rst:1, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h000, ef:3'b000, ea:0, ep:32'h000, ec:8'd0});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:0, ins:32'h7F, pc:32'h100, ef:3'b001, ea:1, ep:32'h100, ec:8'd1});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:0, ins:32'h7F, pc:32'h104, ef:3'b001, ea:1, ep:32'h100, ec:8'd1});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:1, ins:32'h13, pc:32'h108, ef:3'b000, ea:0, ep:32'h100, ec:8'd1});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:0, ins:32'h7F, pc:32'h10C, ef:3'b000, ea:0, ep:32'h100, ec:8'd1});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:0, ins:32'h7F, pc:32'h110, ef:3'b000, ea:0, ep:32'h100, ec:8'd1});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:0, ins:32'h7F, pc:32'h114, ef:3'b001, ea:1, ep:32'h114, ec:8'd2});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:1, ins:32'h13, pc:32'h118, ef:3'b000, ea:0, ep:32'h114, ec:8'd2});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h11C, ef:3'b000, ea:0, ep:32'h114, ec:8'd2});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h120, ef:3'b000, ea:0, ep:32'h114, ec:8'd2});
    tbl.push_back('{rst:0, vld:1, mr:1, mw:1, rw:0, res:0, ins:32'h00, pc:32'h300, ef:3'b010, ea:1, ep:32'h300, ec:8'd3});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:1, ins:32'h13, pc:32'h304, ef:3'b000, ea:0, ep:32'h300, ec:8'd3});
    tbl.push_back('{rst:0, vld:0, mr:1, mw:1, rw:0, res:0, ins:32'h13, pc:32'h308, ef:3'b000, ea:0, ep:32'h300, ec:8'd3});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h30C, ef:3'b000, ea:0, ep:32'h300, ec:8'd3});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:1, rw:1, res:0, ins:32'h13, pc:32'h400, ef:3'b100, ea:1, ep:32'h400, ec:8'd4});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:1, ins:32'h13, pc:32'h404, ef:3'b000, ea:0, ep:32'h400, ec:8'd4});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h408, ef:3'b000, ea:0, ep:32'h400, ec:8'd4});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h40C, ef:3'b000, ea:0, ep:32'h400, ec:8'd4});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:0, ins:32'h7F, pc:32'h500, ef:3'b001, ea:1, ep:32'h500, ec:8'd5});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:1, ins:32'h13, pc:32'h504, ef:3'b000, ea:0, ep:32'h500, ec:8'd5});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h508, ef:3'b000, ea:0, ep:32'h500, ec:8'd5});
    tbl.push_back('{rst:0, vld:0, mr:0, mw:0, rw:0, res:0, ins:32'h13, pc:32'h50C, ef:3'b000, ea:0, ep:32'h500, ec:8'd5});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:1, ins:32'h00A00093, pc:32'h510, ef:3'b000, ea:0, ep:32'h500, ec:8'd5});
    tbl.push_back('{rst:0, vld:1, mr:0, mw:0, rw:0, res:0, ins:32'h7F, pc:32'h600, ef:3'b001, ea:1, ep:32'h600, ec:8'd6});

    set_idle();
    pc_current = 32'h0;

    foreach (tbl[i]) begin
      reset = tbl[i].rst; instr_valid = tbl[i].vld; instr = tbl[i].ins;
      mem_read = tbl[i].mr; mem_write = tbl[i].mw; reg_write = tbl[i].rw;
      pc_write = 0; resume_cpu = tbl[i].res; pc_current = tbl[i].pc;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ea, tbl[i].ep, tbl[i].ec);
    end

    // Stalled PC: flag appears 16 cycles after the first repeated-PC edge and holds.
    do_reset();
    pc_write = 1; pc_current = 32'h200;
    tick();
    tick();
    for (int k = 1; k <= STUCK_LIMIT; k++) begin
      tick();
      if (k == STUCK_LIMIT) check_all("stuck_rise", 3'b100, 1'b1, 32'h200, 8'd1);
      else if (k == STUCK_LIMIT - 1) check_flags("stuck_early", 3'b000, 1'b0);
    end
    for (int k = 0; k < 5; k++) tick();
    check_flags("stuck_hold", 3'b100, 1'b1);
    resume_cpu = 1; tick(); resume_cpu = 0;
    check_flags("stuck_resume", 3'b000, 1'b0);
    set_idle(); tick(); tick();

    // Escalation, and streak cleared by the escalated fault
    three_then(4, 3'b100, "escalate");
    resume_and_blank();
    illegal_fault(32'h2100);
    check_flags("after_escalate", 3'b001, 1'b1);
    three_then(CLEAN_WINDOW - 1, 3'b100, "clean_short");
    three_then(CLEAN_WINDOW, 3'b001, "clean_full");

    // Reset beats resume in HOLD; detection works right after
    do_reset();
    illegal_fault(32'h480);
    check_flags("pre_reset_hold", 3'b001, 1'b1);
    reset = 1; resume_cpu = 1; tick();
    check_all("reset_in_hold", 3'b000, 1'b0, 32'h0, 8'd0);
    illegal_fault(32'h490);
    check_all("after_reset", 3'b001, 1'b1, 32'h490, 8'd1);

    // fault_count saturation
    do_reset();
    for (int i = 0; i < 258; i++) begin
      illegal_fault(32'h800 + 32'(i));
      if (i >= 252) check_count($sformatf("count_sat%0d", i), (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      resume_and_blank();
    end

    // Randomized run against the model
    pc_val = 32'h4000; stall_left = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit quiet;
      quiet = ((cyc / 250) % 2) == 1;
      reset = (cyc == 0) || ($urandom_range(0, 599) == 0);
      resume_cpu = ($urandom_range(0, 9) == 0);
      instr_valid = 1'($urandom_range(0, 1));
      r = $urandom();
      if (!quiet && $urandom_range(0, 9) == 0) instr = r;
      else instr = {r[31:7], legal_ops[$urandom_range(0, 10)]};
      if (quiet) begin
        sel = int'($urandom_range(0, 3));
        mem_read = (sel == 1); mem_write = (sel == 2); reg_write = (sel == 3);
      end else begin
        mem_read = ($urandom_range(0, 2) == 0);
        mem_write = ($urandom_range(0, 2) == 0);
        reg_write = ($urandom_range(0, 2) == 0);
      end
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(0, 29) == 0) stall_left = int'($urandom_range(8, 30));
      else pc_val = pc_val + 32'd4;
      pc_current = pc_val;
      pc_write = (stall_left > 0) ? ($urandom_range(0, 31) != 0) : 1'($urandom_range(0, 1));
      model_edge();
      tick();
      check_all($sformatf("rand%0d", cyc), m_flags, (m_mode == 1), m_pc_saved, 8'(m_count));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
